branch_station: RTL and testbench

- Parametrised branch reservation station.
- Sits between the decoder and the ROB and snoops CDB_N result broadcast channels.
- Holds up to DEPTH conditional branches, wakes operands from the CDB, and resolves the oldest ready branch each cycle.
- Sends {predicted, taken} to the ROB through a registered output, and supports a whole-station flush on mispredict recovery.

---
 rtl/branch_station.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_branch_station.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_station.sv
// -----------------------------------------------------------------------------
// branch_station
//
// Branch reservation station placed between the decoder and the ROB.
// It holds up to DEPTH conditional branches in an age-ordered compacting
// queue (entry 0 is the oldest). Operands wake up by snooping CDB_N result
// broadcast channels. Each cycle the oldest ready branch is resolved, and
// {predicted, taken} goes to the ROB through a registered output.
// A flush squashes the whole station for mispredict recovery.
//
// Optional feature macro: BRA_STATS_EN
//   defined   : stat_issued / stat_mispred are free-running 32-bit counters
//   undefined : both ports are tied to 0 and no counter flops exist
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             squash all entries
//   bra_enable        decoder presents a branch
//   bra_op            funct3 (BEQ=0 BNE=1 BLT=4 BGE=5 BLTU=6 BGEU=7)
//   bra_tag1/2        operand lock tags (0 = operand ready)
//   bra_data1/2       operand values, valid when the matching tag is 0
//   bra_rob           ROB index of the branch
//   bra_pred          predicted-taken bit
//   bra_stall         station full
//   cdb_valid/tag/data CDB channels, channel c in slice c of each bus
//   rob_out_valid     resolution valid
//   rob_out_index     ROB index being resolved
//   rob_out_result    {pred, taken}
//   stat_issued       resolved-branch count
//   stat_mispred      mispredict count
// -----------------------------------------------------------------------------
module branch_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int ROB_W  = 4,
  parameter int CDB_N  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    bra_enable,
  input  logic [2:0]              bra_op,
  input  logic [TAG_W-1:0]        bra_tag1,
  input  logic [TAG_W-1:0]        bra_tag2,
  input  logic [DATA_W-1:0]       bra_data1,
  input  logic [DATA_W-1:0]       bra_data2,
  input  logic [ROB_W-1:0]        bra_rob,
  input  logic                    bra_pred,
  output logic                    bra_stall,
  input  logic [CDB_N-1:0]        cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_N*DATA_W-1:0] cdb_data,
  output logic                    rob_out_valid,
  output logic [ROB_W-1:0]        rob_out_index,
  output logic [1:0]              rob_out_result,
  output logic [31:0]             stat_issued,
  output logic [31:0]             stat_mispred
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SNP_W = TAG_W + DATA_W;

  // ---------------------------------------------------------------------------
  // Snoop one operand against the CDB. Returns {tag, data} after wakeup.
  // Channels are scanned high to low so the lowest matching channel is the
  // last writer and wins. A zero tag is already ready, so it never matches.
  // ---------------------------------------------------------------------------
  function automatic logic [SNP_W-1:0] f_snoop(input logic [TAG_W-1:0]  tag,
                                               input logic [DATA_W-1:0] data);
    logic [TAG_W-1:0]  t;
    logic [DATA_W-1:0] d;
    t = tag;
    d = data;
    if (tag != '0) begin
      for (int c = CDB_N - 1; c >= 0; c--) begin
        if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag)) begin
          t = '0;
          d = cdb_data[c*DATA_W +: DATA_W];
        end
      end
    end
    return {t, d};
  endfunction

  // Branch condition evaluation; undefined funct3 codes resolve not-taken.
  function automatic logic f_taken(input logic [2:0]        op,
                                   input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    logic tk;
    case (op)
      3'd0:    tk = (a == b);
      3'd1:    tk = (a != b);
      3'd4:    tk = ($signed(a) <  $signed(b));
      3'd5:    tk = ($signed(a) >= $signed(b));
      3'd6:    tk = (a <  b);
      3'd7:    tk = (a >= b);
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]  r_valid;
  logic [2:0]        r_op    [DEPTH];
  logic [TAG_W-1:0]  r_tag1  [DEPTH];
  logic [TAG_W-1:0]  r_tag2  [DEPTH];
  logic [DATA_W-1:0] r_data1 [DEPTH];
  logic [DATA_W-1:0] r_data2 [DEPTH];
  logic [ROB_W-1:0]  r_rob   [DEPTH];
  logic [DEPTH-1:0]  r_pred;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_out_valid;
  logic [ROB_W-1:0]  r_out_index;
  logic [1:0]        r_out_result;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]  w_ready;
  logic [IDX_W-1:0]  w_sel;
  logic              w_issue;
  logic              w_taken;
  logic              w_insert;
  logic [IDX_W-1:0]  w_tail;

  // Post-shift view of the queue
  logic [DEPTH-1:0]  w_sh_valid;
  logic [2:0]        w_sh_op    [DEPTH];
  logic [TAG_W-1:0]  w_sh_tag1  [DEPTH];
  logic [TAG_W-1:0]  w_sh_tag2  [DEPTH];
  logic [DATA_W-1:0] w_sh_data1 [DEPTH];
  logic [DATA_W-1:0] w_sh_data2 [DEPTH];
  logic [ROB_W-1:0]  w_sh_rob   [DEPTH];
  logic [DEPTH-1:0]  w_sh_pred;

  // Post-shift view after CDB wakeup
  logic [TAG_W-1:0]  w_wk_tag1  [DEPTH];
  logic [TAG_W-1:0]  w_wk_tag2  [DEPTH];
  logic [DATA_W-1:0] w_wk_data1 [DEPTH];
  logic [DATA_W-1:0] w_wk_data2 [DEPTH];

  // Final next-state after the insert overlay
  logic [DEPTH-1:0]  w_valid_next;
  logic [2:0]        w_op_next    [DEPTH];
  logic [TAG_W-1:0]  w_tag1_next  [DEPTH];
  logic [TAG_W-1:0]  w_tag2_next  [DEPTH];
  logic [DATA_W-1:0] w_data1_next [DEPTH];
  logic [DATA_W-1:0] w_data2_next [DEPTH];
  logic [ROB_W-1:0]  w_rob_next   [DEPTH];
  logic [DEPTH-1:0]  w_pred_next;
  logic [CNT_W-1:0]  w_cnt_next;

  // Incoming operands snooped in the insert cycle (bypass)
  logic [SNP_W-1:0]  w_in_snp1;
  logic [SNP_W-1:0]  w_in_snp2;

  // ---------------------------------------------------------------------------
  // Per-entry readiness, compaction shift and wakeup
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Source of the shift; the top entry has nothing above it.
      localparam int SRC  = (gi == DEPTH - 1) ? gi : gi + 1;
      localparam bit LAST = (gi == DEPTH - 1);

      logic             w_shift;
      logic [SNP_W-1:0] w_snp1;
      logic [SNP_W-1:0] w_snp2;

      assign w_ready[gi] = r_valid[gi] && (r_tag1[gi] == '0) && (r_tag2[gi] == '0);

      // Entries at or above the issued one move down by one slot.
      assign w_shift = w_issue && (IDX_W'(gi) >= w_sel);

      assign w_sh_valid[gi] = w_shift ? (!LAST && r_valid[SRC]) : r_valid[gi];
      assign w_sh_op[gi]    = w_shift ? r_op[SRC]    : r_op[gi];
      assign w_sh_tag1[gi]  = w_shift ? r_tag1[SRC]  : r_tag1[gi];
      assign w_sh_tag2[gi]  = w_shift ? r_tag2[SRC]  : r_tag2[gi];
      assign w_sh_data1[gi] = w_shift ? r_data1[SRC] : r_data1[gi];
      assign w_sh_data2[gi] = w_shift ? r_data2[SRC] : r_data2[gi];
      assign w_sh_rob[gi]   = w_shift ? r_rob[SRC]   : r_rob[gi];
      assign w_sh_pred[gi]  = w_shift ? r_pred[SRC]  : r_pred[gi];

      // Wakeup lands on the post-shift slot so it follows the moving entry.
      assign w_snp1 = f_snoop(w_sh_tag1[gi], w_sh_data1[gi]);
      assign w_snp2 = f_snoop(w_sh_tag2[gi], w_sh_data2[gi]);
      assign {w_wk_tag1[gi], w_wk_data1[gi]} = w_snp1;
      assign {w_wk_tag2[gi], w_wk_data2[gi]} = w_snp2;
    end
  endgenerate

  // Oldest ready entry wins.
  always_comb begin
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel = IDX_W'(i);
      end
    end
  end

  assign w_issue  = |w_ready;
  assign w_taken  = f_taken(r_op[w_sel], r_data1[w_sel], r_data2[w_sel]);

  // Stall is taken from the pre-issue count, so a full station never accepts.
  assign bra_stall = (r_cnt == CNT_W'(DEPTH));
  assign w_insert  = bra_enable && !bra_stall && !flush;
  assign w_tail    = w_issue ? IDX_W'(r_cnt - CNT_W'(1)) : IDX_W'(r_cnt);

  assign w_in_snp1 = f_snoop(bra_tag1, bra_data1);
  assign w_in_snp2 = f_snoop(bra_tag2, bra_data2);

  // ---------------------------------------------------------------------------
  // Next-state: shifted and woken queue with the new branch overlaid at tail
  // ---------------------------------------------------------------------------
  always_comb begin
    w_valid_next = w_sh_valid;
    w_pred_next  = w_sh_pred;
    for (int i = 0; i < DEPTH; i++) begin
      w_op_next[i]    = w_sh_op[i];
      w_tag1_next[i]  = w_wk_tag1[i];
      w_tag2_next[i]  = w_wk_tag2[i];
      w_data1_next[i] = w_wk_data1[i];
      w_data2_next[i] = w_wk_data2[i];
      w_rob_next[i]   = w_sh_rob[i];
    end
    if (w_insert) begin
      w_valid_next[w_tail] = 1'b1;
      w_pred_next[w_tail]  = bra_pred;
      w_op_next[w_tail]    = bra_op;
      w_rob_next[w_tail]   = bra_rob;
      {w_tag1_next[w_tail], w_data1_next[w_tail]} = w_in_snp1;
      {w_tag2_next[w_tail], w_data2_next[w_tail]} = w_in_snp2;
    end
    w_cnt_next = r_cnt - CNT_W'(w_issue) + CNT_W'(w_insert);
  end

  // ---------------------------------------------------------------------------
  // Control state and ROB output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_index  <= '0;
      r_out_result <= '0;
    end else if (flush) begin
      // Flush squashes everything pending; the last reported index and
      // result are left as they were.
      r_valid     <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_valid     <= w_valid_next;
      r_cnt       <= w_cnt_next;
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_index  <= r_rob[w_sel];
        r_out_result <= {r_pred[w_sel], w_taken};
      end
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    r_pred <= w_pred_next;
    for (int i = 0; i < DEPTH; i++) begin
      r_op[i]    <= w_op_next[i];
      r_tag1[i]  <= w_tag1_next[i];
      r_tag2[i]  <= w_tag2_next[i];
      r_data1[i] <= w_data1_next[i];
      r_data2[i] <= w_data2_next[i];
      r_rob[i]   <= w_rob_next[i];
    end
  end

  assign rob_out_valid  = r_out_valid;
  assign rob_out_index  = r_out_index;
  assign rob_out_result = r_out_result;

  // ---------------------------------------------------------------------------
  // Resolution statistics
  // ---------------------------------------------------------------------------
`ifdef BRA_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_mispred;

  // Counts follow the output register load; flush loads 0 so it never counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_issued  <= '0;
      r_stat_mispred <= '0;
    end else if (w_issue && !flush) begin
      r_stat_issued <= r_stat_issued + 32'd1;
      if (r_pred[w_sel] != w_taken) begin
        r_stat_mispred <= r_stat_mispred + 32'd1;
      end
    end
  end

  assign stat_issued  = r_stat_issued;
  assign stat_mispred = r_stat_mispred;
`else
  assign stat_issued  = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_station.sv
// -----------------------------------------------------------------------------
// tb_branch_station
//
// Directed testbench for branch_station with default parameters
// (DEPTH=4, DATA_W=32, TAG_W=4, ROB_W=4, CDB_N=2). Inputs change and outputs
// are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_branch_station;

  localparam logic [2:0] BEQ  = 3'd0;
  localparam logic [2:0] BNE  = 3'd1;
  localparam logic [2:0] BLT  = 3'd4;
  localparam logic [2:0] BGE  = 3'd5;
  localparam logic [2:0] BLTU = 3'd6;
  localparam logic [2:0] BGEU = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        bra_enable;
  logic [2:0]  bra_op;
  logic [3:0]  bra_tag1, bra_tag2;
  logic [31:0] bra_data1, bra_data2;
  logic [3:0]  bra_rob;
  logic        bra_pred;
  logic        bra_stall;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        rob_out_valid;
  logic [3:0]  rob_out_index;
  logic [1:0]  rob_out_result;
  logic [31:0] stat_issued, stat_mispred;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic [3:0]  rob;
    logic [1:0]  exp;
  } vec_t;

  vec_t vecs [12];

  branch_station dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .bra_enable     (bra_enable),
    .bra_op         (bra_op),
    .bra_tag1       (bra_tag1),
    .bra_tag2       (bra_tag2),
    .bra_data1      (bra_data1),
    .bra_data2      (bra_data2),
    .bra_rob        (bra_rob),
    .bra_pred       (bra_pred),
    .bra_stall      (bra_stall),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .rob_out_valid  (rob_out_valid),
    .rob_out_index  (rob_out_index),
    .rob_out_result (rob_out_result),
    .stat_issued    (stat_issued),
    .stat_mispred   (stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    flush      = 1'b0;
    bra_enable = 1'b0;
    bra_op     = 3'd0;
    bra_tag1   = '0;
    bra_tag2   = '0;
    bra_data1  = '0;
    bra_data2  = '0;
    bra_rob    = '0;
    bra_pred   = 1'b0;
    cdb_valid  = '0;
    cdb_tag    = '0;
    cdb_data   = '0;
  endtask

  task automatic drive_branch(input logic [2:0] op, input logic [3:0] t1, input logic [31:0] d1,
                              input logic [3:0] t2, input logic [31:0] d2,
                              input logic [3:0] rob, input logic pred);
    bra_enable = 1'b1;
    bra_op     = op;
    bra_tag1   = t1;
    bra_data1  = d1;
    bra_tag2   = t2;
    bra_data2  = d2;
    bra_rob    = rob;
    bra_pred   = pred;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rob_out_valid); end
    checks++; if (rob_out_index !== 4'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", rob_out_index); end
    checks++; if (rob_out_result !== 2'b00) begin failures++; $display("FAIL reset_result got=%b exp=00", rob_out_result); end
    checks++; if (bra_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bra_stall); end
    checks++; if (stat_issued !== 32'd0) begin failures++; $display("FAIL reset_stat_issued got=%0d exp=0", stat_issued); end
    checks++; if (stat_mispred !== 32'd0) begin failures++; $display("FAIL reset_stat_mispred got=%0d exp=0", stat_mispred); end
    // Reset while a ready branch is waiting: it must vanish without output.
    drive_branch(BEQ, 4'd0, 32'd5, 4'd0, 32'd5, 4'd3, 1'b1);
    tick();
    bra_enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%0b exp=0", rob_out_valid); end
    checks++; if (rob_out_index !== 4'd0) begin failures++; $display("FAIL midreset_index got=%0d exp=0", rob_out_index); end
    tick();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL midreset_after_valid got=%0b exp=0", rob_out_valid); end
    $display("reset done");
  endtask

  task automatic test_beq;
    drive_branch(BEQ, 4'd0, 32'd5, 4'd0, 32'd5, 4'd3, 1'b1);
    tick();
    bra_enable = 1'b0;
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL beq_edge1_valid got=%0b exp=0", rob_out_valid); end
    tick();
    checks++; if (rob_out_valid !== 1'b1) begin failures++; $display("FAIL beq_valid got=%0b exp=1", rob_out_valid); end
    checks++; if (rob_out_index !== 4'd3) begin failures++; $display("FAIL beq_index got=%0d exp=3", rob_out_index); end
    checks++; if (rob_out_result !== 2'b11) begin failures++; $display("FAIL beq_result got=%b exp=11", rob_out_result); end
    $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
    tick();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL beq_after_valid got=%0b exp=0", rob_out_valid); end
    checks++; if (rob_out_index !== 4'd3) begin failures++; $display("FAIL beq_hold_index got=%0d exp=3", rob_out_index); end
    checks++; if (rob_out_result !== 2'b11) begin failures++; $display("FAIL beq_hold_result got=%b exp=11", rob_out_result); end
  endtask

  // Back-to-back inserts; each branch resolves one edge after the next insert.
  task automatic test_compare;
    vecs[0]  = '{BLT,  32'hFFFF_FFFF, 32'h1,         1'b0, 4'd4,  2'b01};
    vecs[1]  = '{BLTU, 32'hFFFF_FFFF, 32'h1,         1'b1, 4'd5,  2'b10};
    vecs[2]  = '{BGEU, 32'hFFFF_FFFF, 32'h1,         1'b1, 4'd6,  2'b11};
    vecs[3]  = '{BGE,  32'hFFFF_FFFF, 32'h1,         1'b0, 4'd7,  2'b00};
    vecs[4]  = '{BNE,  32'd5,         32'd5,         1'b1, 4'd8,  2'b10};
    vecs[5]  = '{3'd2, 32'd5,         32'd5,         1'b0, 4'd9,  2'b00};
    vecs[6]  = '{3'd3, 32'd0,         32'd0,         1'b0, 4'd10, 2'b00};
    vecs[7]  = '{BEQ,  32'h8000_0000, 32'h8000_0000, 1'b0, 4'd11, 2'b01};
    vecs[8]  = '{BLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 4'd12, 2'b01};
    vecs[9]  = '{BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 4'd13, 2'b01};
    vecs[10] = '{BLTU, 32'd3,         32'd3,         1'b0, 4'd14, 2'b00};
    vecs[11] = '{BGE,  32'd3,         32'd3,         1'b1, 4'd15, 2'b11};
    for (int k = 0; k <= 12; k++) begin
      if (k < 12) drive_branch(vecs[k].op, 4'd0, vecs[k].a, 4'd0, vecs[k].b, vecs[k].rob, vecs[k].pred);
      else        bra_enable = 1'b0;
      tick();
      if (k > 0) begin
        checks++; if (rob_out_valid !== 1'b1) begin failures++; $display("FAIL cmp%0d_valid got=%0b exp=1", k-1, rob_out_valid); end
        checks++; if (rob_out_index !== vecs[k-1].rob) begin failures++; $display("FAIL cmp%0d_index got=%0d exp=%0d", k-1, rob_out_index, vecs[k-1].rob); end
        checks++; if (rob_out_result !== vecs[k-1].exp) begin failures++; $display("FAIL cmp%0d_result got=%b exp=%b", k-1, rob_out_result, vecs[k-1].exp); end
        $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
      end
    end
    tick();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL cmp_drain_valid got=%0b exp=0", rob_out_valid); end
  endtask

  task automatic test_wakeup_order;
    drive_branch(BEQ, 4'd5, 32'hDEAD, 4'd0, 32'd7, 4'd1, 1'b1);
    tick();
    drive_branch(BEQ, 4'd0, 32'd1, 4'd0, 32'd1, 4'd2, 1'b0);
    tick();
    bra_enable = 1'b0;
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL wake_pre_valid got=%0b exp=0", rob_out_valid); end
    // Both channels carry tag 5; channel 0 (data 7) must win.
    cdb_valid = 2'b11;
    cdb_tag   = {4'd5, 4'd5};
    cdb_data  = {32'd9, 32'd7};
    tick();
    cdb_valid = 2'b00;
    checks++; if (rob_out_valid !== 1'b1) begin failures++; $display("FAIL wake_first_valid got=%0b exp=1", rob_out_valid); end
    checks++; if (rob_out_index !== 4'd2) begin failures++; $display("FAIL wake_first_index got=%0d exp=2", rob_out_index); end
    checks++; if (rob_out_result !== 2'b01) begin failures++; $display("FAIL wake_first_result got=%b exp=01", rob_out_result); end
    $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
    tick();
    checks++; if (rob_out_valid !== 1'b1) begin failures++; $display("FAIL wake_second_valid got=%0b exp=1", rob_out_valid); end
    checks++; if (rob_out_index !== 4'd1) begin failures++; $display("FAIL wake_second_index got=%0d exp=1", rob_out_index); end
    checks++; if (rob_out_result !== 2'b11) begin failures++; $display("FAIL wake_second_result got=%b exp=11", rob_out_result); end
    $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
    tick();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL wake_drain_valid got=%0b exp=0", rob_out_valid); end
  endtask

  task automatic test_full_stall;
    for (int i = 0; i < 4; i++) begin
      drive_branch(BEQ, 4'(i + 1), 32'd0, 4'd0, 32'h10, 4'(i + 1), 1'b0);
      tick();
      if (i == 2) begin
        checks++; if (bra_stall !== 1'b0) begin failures++; $display("FAIL full_three_stall got=%0b exp=0", bra_stall); end
      end
    end
    checks++; if (bra_stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%0b exp=1", bra_stall); end
    // Decoder holds a ready branch while stalled; it must not be stored yet.
    drive_branch(BEQ, 4'd0, 32'd0, 4'd0, 32'd0, 4'd5, 1'b0);
    tick();
    checks++; if (bra_stall !== 1'b1) begin failures++; $display("FAIL full_ignored_stall got=%0b exp=1", bra_stall); end
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL full_ignored_valid got=%0b exp=0", rob_out_valid); end
    // Wake rob 2 (tag 2) on channel 1.
    cdb_valid = 2'b10;
    cdb_tag   = {4'd2, 4'd0};
    cdb_data  = {32'h10, 32'd0};
    tick();
    checks++; if (bra_stall !== 1'b1) begin failures++; $display("FAIL full_wake_stall got=%0b exp=1", bra_stall); end
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL full_wake_valid got=%0b exp=0", rob_out_valid); end
    // Rob 2 issues while rob 4 (tag 4) wakes as it shifts down.
    cdb_valid = 2'b01;
    cdb_tag   = {4'd0, 4'd4};
    cdb_data  = {32'd0, 32'h10};
    tick();
    cdb_valid = 2'b00;
    checks++; if (rob_out_valid !== 1'b1) begin failures++; $display("FAIL full_issue_valid got=%0b exp=1", rob_out_valid); end
    checks++; if (rob_out_index !== 4'd2) begin failures++; $display("FAIL full_issue_index got=%0d exp=2", rob_out_index); end
    checks++; if (rob_out_result !== 2'b01) begin failures++; $display("FAIL full_issue_result got=%b exp=01", rob_out_result); end
    checks++; if (bra_stall !== 1'b0) begin failures++; $display("FAIL full_drop_stall got=%0b exp=0", bra_stall); end
    $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
    // Held rob 5 is accepted now while rob 4 issues.
    tick();
    bra_enable = 1'b0;
    checks++; if (rob_out_index !== 4'd4) begin failures++; $display("FAIL full_shifted_index got=%0d exp=4", rob_out_index); end
    checks++; if (rob_out_valid !== 1'b1) begin failures++; $display("FAIL full_shifted_valid got=%0b exp=1", rob_out_valid); end
    checks++; if (bra_stall !== 1'b0) begin failures++; $display("FAIL full_three_left_stall got=%0b exp=0", bra_stall); end
    $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
    tick();
    checks++; if (rob_out_index !== 4'd5) begin failures++; $display("FAIL full_new_index got=%0d exp=5", rob_out_index); end
    checks++; if (rob_out_result !== 2'b01) begin failures++; $display("FAIL full_new_result got=%b exp=01", rob_out_result); end
    $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
    tick();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL full_drain_valid got=%0b exp=0", rob_out_valid); end
  endtask

  task automatic test_flush;
    // Station holds rob 1 and rob 3; add rob 6 to reach three entries.
    drive_branch(BEQ, 4'd6, 32'd0, 4'd0, 32'd0, 4'd6, 1'b0);
    tick();
    flush = 1'b1;
    drive_branch(BEQ, 4'd0, 32'd0, 4'd0, 32'd0, 4'd7, 1'b1);
    cdb_valid = 2'b01;
    cdb_tag   = {4'd0, 4'd1};
    cdb_data  = {32'd0, 32'd0};
    tick();
    idle();
    checks++; if (bra_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", bra_stall); end
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", rob_out_valid); end
    tick();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL flush_after1_valid got=%0b exp=0", rob_out_valid); end
    tick();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL flush_after2_valid got=%0b exp=0", rob_out_valid); end
    // An empty station takes exactly four entries before stalling.
    for (int i = 0; i < 3; i++) begin
      drive_branch(BEQ, 4'd7, 32'd0, 4'd0, 32'd0, 4'(i), 1'b0);
      tick();
    end
    checks++; if (bra_stall !== 1'b0) begin failures++; $display("FAIL flush_refill3_stall got=%0b exp=0", bra_stall); end
    tick();
    bra_enable = 1'b0;
    checks++; if (bra_stall !== 1'b1) begin failures++; $display("FAIL flush_refill4_stall got=%0b exp=1", bra_stall); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bra_stall !== 1'b0) begin failures++; $display("FAIL flush_clean_stall got=%0b exp=0", bra_stall); end
    $display("flush done");
  endtask

  task automatic test_insert_bypass;
    drive_branch(BEQ, 4'd0, 32'h33, 4'd9, 32'h0, 4'd9, 1'b1);
    cdb_valid = 2'b11;
    cdb_tag   = {4'd9, 4'd3};
    cdb_data  = {32'h33, 32'h0};
    tick();
    idle();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL bypass_edge1_valid got=%0b exp=0", rob_out_valid); end
    tick();
    checks++; if (rob_out_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%0b exp=1", rob_out_valid); end
    checks++; if (rob_out_index !== 4'd9) begin failures++; $display("FAIL bypass_index got=%0d exp=9", rob_out_index); end
    checks++; if (rob_out_result !== 2'b11) begin failures++; $display("FAIL bypass_result got=%b exp=11", rob_out_result); end
    $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
    // A tag-0 broadcast must not overwrite operands that are already ready.
    drive_branch(BEQ, 4'd0, 32'd5, 4'd0, 32'd5, 4'd10, 1'b1);
    cdb_valid = 2'b01;
    cdb_tag   = {4'd0, 4'd0};
    cdb_data  = {32'd6, 32'd6};
    tick();
    idle();
    tick();
    checks++; if (rob_out_index !== 4'd10) begin failures++; $display("FAIL tag0_index got=%0d exp=10", rob_out_index); end
    checks++; if (rob_out_result !== 2'b11) begin failures++; $display("FAIL tag0_result got=%b exp=11", rob_out_result); end
    $display("resolve rob=%0d result=%b", rob_out_index, rob_out_result);
    tick();
    checks++; if (rob_out_valid !== 1'b0) begin failures++; $display("FAIL bypass_drain_valid got=%0b exp=0", rob_out_valid); end
  endtask

  task automatic test_stats;
    logic [31:0] exp_iss;
    logic [31:0] exp_mis;
`ifdef BRA_STATS_EN
    exp_iss = 32'd5;
    exp_mis = 32'd2;
`else
    exp_iss = 32'd0;
    exp_mis = 32'd0;
`endif
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_branch(BEQ,  4'd0, 32'd1, 4'd0, 32'd1, 4'd1, 1'b1); tick();
    drive_branch(BEQ,  4'd0, 32'd1, 4'd0, 32'd2, 4'd2, 1'b1); tick();
    drive_branch(BNE,  4'd0, 32'd1, 4'd0, 32'd2, 4'd3, 1'b1); tick();
    drive_branch(BLTU, 4'd0, 32'd2, 4'd0, 32'd1, 4'd4, 1'b1); tick();
    drive_branch(BGEU, 4'd0, 32'd2, 4'd0, 32'd1, 4'd5, 1'b1); tick();
    bra_enable = 1'b0;
    tick();
    tick();
    checks++; if (stat_issued !== exp_iss) begin failures++; $display("FAIL stat_issued got=%0d exp=%0d", stat_issued, exp_iss); end
    checks++; if (stat_mispred !== exp_mis) begin failures++; $display("FAIL stat_mispred got=%0d exp=%0d", stat_mispred, exp_mis); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (stat_issued !== exp_iss) begin failures++; $display("FAIL stat_flush_issued got=%0d exp=%0d", stat_issued, exp_iss); end
    checks++; if (stat_mispred !== exp_mis) begin failures++; $display("FAIL stat_flush_mispred got=%0d exp=%0d", stat_mispred, exp_mis); end
    $display("stats issued=%0d mispred=%0d", stat_issued, stat_mispred);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_beq();
    test_compare();
    test_wakeup_order();
    test_full_stall();
    test_flush();
    test_insert_bypass();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
